ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Time-multiplexed driver for a common-anode multi-digit seven-segment display. It is the consumer side of the BCD-to-segment decode path.
- Accepts a packed BCD word plus decimal-point mask through a load strobe and holds it in a shadow buffer.
- Commits the buffered word only at frame boundaries, so the display never tears.
- Scans one digit at a time at a prescaled rate, driving active-low segment and anode lines.

Parameters:
- DIGITS, 4, number of display digits (>=2).
- SCAN_DIV, 100000, clk cycles per digit slot (>=1); 100 MHz gives 1 kHz per digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- load  in  1  one-cycle strobe; captures value and dp_mask.
- value  in  4*DIGITS  packed BCD; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp_mask  in  DIGITS  1 = light decimal point of digit i.
- pending  out  1  shadow holds an uncommitted word.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.
- segs  out  8  active-low {a,b,c,d,e,f,g,dp}, bit7=a ... bit0=dp.
- an  out  DIGITS  active-low anode select, one-hot-low.

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - segs=8'hFF, an=all ones, pending=0, frame_tick=0.
  - Prescaler=0, digit index=0.
  - Display and shadow registers: all digits 4'hF (blank), dp all 0.
- Reset mid-operation:
  - Discards any pending word.
  - Next cycle after rst falls: an=~(1<<0), segs=8'hFF.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - Terminal count = (prescaler==SCAN_DIV-1).
  - SCAN_DIV=1: terminal every cycle.
- Digit index:
  - Advances at terminal count, DIGITS-1 wraps to 0.
  - Frame boundary = terminal count while index==DIGITS-1.
- frame_tick:
  - Registered; high the cycle after a frame boundary edge.
  - Asserted exactly once per DIGITS*SCAN_DIV cycles.
- Load/commit handshake, evaluated each edge:
  - load=1: shadow<=value/dp_mask; pending<=1. Last write wins; a load while pending overwrites with no error.
  - At a frame boundary with load=1: display<=value/dp_mask directly (bypass), pending<=0.
  - At a frame boundary with pending=1 and load=0: display<=shadow, pending<=0.
  - Otherwise display is unchanged.
  - Committed data appears on segs starting with digit 0 of the next frame.
- Output stage, registered with 1-cycle latency from index/display:
  - an = ~(1<<index).
  - segs[7:1] = decode(display digit[index]); segs[0] = ~dp[index].
- Decode table (active-low, bits a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Codes 10..15: 1111111 (blank); dp is still honoured.
- Ghost suppression: exactly one anode low every cycle after reset; never zero, never two.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i>0 is blanked (segs[7:1]=7'h7F) when digit i and all higher digits of the committed word are 0.
  - Digit 0 is never blanked by this rule.
  - dp still honoured, and a set dp on digit i or any higher digit disables suppression for digits <=i.
- Undefined: zeros are always displayed.
- Suppression is computed from the display register only; the shadow never affects it.

Test Plan (DIGITS=4, SCAN_DIV=4 unless noted):
- Reset release -> an sequence 1110,1101,1011,0111 each held 4 cycles; segs=8'hFF throughout; frame_tick pulses every 16 cycles.
- load value=16'h1234, dp_mask=0 mid-frame -> pending=1 until boundary; next frame segs digit0=8'h99(4), digit1=8'h0D(3), digit2=8'h25(2), digit3=8'h9F(1); pending=0.
- Two loads in one frame (16'h1111 then 16'h5678) -> only 5678 displayed; no frame shows 1111.
- load coincident with frame boundary edge, value=16'h0009 -> committed that edge; digit0 shows 8'h09 on the following frame; pending stays 0.
- value=16'h00A7, dp_mask=4'b0010 -> digit1 segs=8'hFE (blank, dp on), digit0=8'h1F; with SSD_LEADING_ZERO_BLANK_EN digits 3,2 = 8'hFF; without it they show 8'h03.
- rst asserted mid-frame with pending=1 -> next edge segs=8'hFF, an=1111, pending=0; the old word is never displayed after release.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with a frame-synchronous shadow buffer.
// Optional leading-zero blanking is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic                  pending,
   output logic                  frame_tick,
   output logic [7:0]            segs,
   output logic [DIGITS-1:0]     an
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [PW-1:0]            presc_q, presc_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [DIGITS-1:0][3:0]   shadow_val_q, shadow_val_d;
   logic [DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
   logic [DIGITS-1:0][3:0]   disp_val_q, disp_val_d;
   logic [DIGITS-1:0]        disp_dp_q, disp_dp_d;
   logic                     pending_q, pending_d;
   logic                     frame_tick_q, frame_tick_d;
   logic [7:0]               segs_q, segs_d;
   logic [DIGITS-1:0]        an_q, an_d;

   logic                     term;
   logic                     boundary;
   logic [DIGITS-1:0]        lz_blank;
   logic [DIGITS-1:0][3:0]   value_arr;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0000001;
         4'd1:    decode = 7'b1001111;
         4'd2:    decode = 7'b0010010;
         4'd3:    decode = 7'b0000110;
         4'd4:    decode = 7'b1001100;
         4'd5:    decode = 7'b0100100;
         4'd6:    decode = 7'b0100000;
         4'd7:    decode = 7'b0001111;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0000100;
         default: decode = 7'b1111111;
      endcase
   endfunction

   assign value_arr = value;
   assign term      = (presc_q == PRESC_LAST);
   assign boundary  = term && (idx_q == IDX_LAST);

`ifdef SSD_LEADING_ZERO_BLANK_EN
   // A digit is suppressed only if it and every higher digit are zero with no dp lit.
   always_comb begin
      lz_blank = '0;
      for (int i = 1; i < DIGITS; i++) begin
         lz_blank[i] = 1'b1;
         for (int j = i; j < DIGITS; j++)
            if ((|disp_val_q[j]) || disp_dp_q[j]) lz_blank[i] = 1'b0;
      end
   end
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      presc_d = term ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (term) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      frame_tick_d = boundary;
   end

   // Shadow takes every load; display only changes on the frame boundary,
   // where a same-cycle load bypasses the shadow.
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pending_d    = pending_q;
      if (load) begin
         shadow_val_d = value_arr;
         shadow_dp_d  = dp_mask;
         pending_d    = 1'b1;
      end
      if (boundary) begin
         if (load) begin
            disp_val_d = value_arr;
            disp_dp_d  = dp_mask;
         end else if (pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
         end
         pending_d = 1'b0;
      end
   end

   always_comb begin
      an_d   = ~(DIGITS'(1) << idx_q);
      segs_d = {lz_blank[idx_q] ? 7'h7F : decode(disp_val_q[idx_q]), ~disp_dp_q[idx_q]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         shadow_val_q <= {DIGITS{4'hF}};
         shadow_dp_q  <= '0;
         disp_val_q   <= {DIGITS{4'hF}};
         disp_dp_q    <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         segs_q       <= 8'hFF;
         an_q         <= '1;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pending_q    <= pending_d;
         frame_tick_q <= frame_tick_d;
         segs_q       <= segs_d;
         an_q         <= an_d;
      end
   end

   assign pending    = pending_q;
   assign frame_tick = frame_tick_q;
   assign segs       = segs_q;
   assign an         = an_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (DIGITS=4, SCAN_DIV=4): expected digit slots are
// queued when a word is committed and drained slot by slot as the scan emits them.
module tb_ssd_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_mask = '0;
   logic        pending, frame_tick;
   logic [7:0]  segs;
   logic [3:0]  an;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] segs;
   } slot_t;

   slot_t exp_q[$];
   int    cyc = 0;
   int    n_cmp = 0;
   int    n_mis = 0;

   ssd_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
      .pending(pending), .frame_tick(frame_tick), .segs(segs), .an(an)
   );

   always #5 clk = ~clk;

   // Edges since reset release; after edge n the outputs reflect scan state n-1.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      logic [6:0] t [0:9];
      t[0] = 7'b0000001; t[1] = 7'b1001111; t[2] = 7'b0010010; t[3] = 7'b0000110;
      t[4] = 7'b1001100; t[5] = 7'b0100100; t[6] = 7'b0100000; t[7] = 7'b0001111;
      t[8] = 7'b0000000; t[9] = 7'b0000100;
      return (d > 4'd9) ? 7'h7F : t[d];
   endfunction

   task automatic push_word(input logic [15:0] v, input logic [3:0] dp);
      slot_t s;
      logic  blank;
      for (int d = 0; d < 4; d++) begin
         blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
         if (d > 0) begin
            blank = 1'b1;
            for (int k = d; k < 4; k++)
               if (v[4*k +: 4] != 4'd0 || dp[k]) blank = 1'b0;
         end
`endif
         s.an   = ~(4'b0001 << d);
         s.segs = {blank ? 7'h7F : ref_seg(v[4*d +: 4]), ~dp[d]};
         exp_q.push_back(s);
      end
   endtask

   task automatic go_neg(input int t);
      int guard = 0;
      while (cyc < t && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != t) begin
         n_cmp++; n_mis++;
         $display("FAIL go_neg: reached cycle %0d, wanted %0d", cyc, t);
      end
   endtask

   task automatic drain_frame(input int n0);
      slot_t e;
      logic  ft;
      for (int d = 0; d < 4; d++) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL scoreboard_empty at cycle %0d", n0 + 4*d);
            return;
         end
         e = exp_q.pop_front();
         for (int c = 0; c < 4; c++) begin
            go_neg(n0 + 4*d + c);
            ft = ((cyc % 16) == 0);
            n_cmp += 3;
            if (an !== e.an) begin
               n_mis++;
               $display("FAIL an cyc=%0d got=%b want=%b", cyc, an, e.an);
            end
            if (segs !== e.segs) begin
               n_mis++;
               $display("FAIL segs cyc=%0d digit=%0d got=%h want=%h", cyc, d, segs, e.segs);
            end
            if (frame_tick !== ft) begin
               n_mis++;
               $display("FAIL frame_tick cyc=%0d got=%b want=%b", cyc, frame_tick, ft);
            end
         end
      end
   endtask

   task automatic do_load(input int t, input logic [15:0] v, input logic [3:0] dp);
      go_neg(t);
      load = 1'b1; value = v; dp_mask = dp;
      go_neg(t + 1);
      load = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_cmp += 4;
      if (segs !== 8'hFF)    begin n_mis++; $display("FAIL reset_segs got=%h want=ff", segs); end
      if (an !== 4'hF)       begin n_mis++; $display("FAIL reset_an got=%b want=1111", an); end
      if (pending !== 1'b0)  begin n_mis++; $display("FAIL reset_pending got=%b want=0", pending); end
      if (frame_tick !== 1'b0) begin n_mis++; $display("FAIL reset_ft got=%b want=0", frame_tick); end
      rst = 1'b0;
      push_word(16'hFFFF, 4'b0000);
      drain_frame(1);
   endtask

   task automatic test_load;
      push_word(16'hFFFF, 4'b0000);
      fork
         drain_frame(17);
         begin
            do_load(20, 16'h1234, 4'b0000);
            n_cmp++;
            if (pending !== 1'b1) begin n_mis++; $display("FAIL load_pending got=%b want=1", pending); end
            go_neg(31);
            n_cmp++;
            if (pending !== 1'b1) begin n_mis++; $display("FAIL hold_pending got=%b want=1", pending); end
            go_neg(32);
            n_cmp++;
            if (pending !== 1'b0) begin n_mis++; $display("FAIL commit_pending got=%b want=0", pending); end
         end
      join
      push_word(16'h1234, 4'b0000);
      drain_frame(33);
   endtask

   task automatic test_back_to_back;
      push_word(16'h1234, 4'b0000);
      fork
         drain_frame(49);
         begin
            do_load(50, 16'h1111, 4'b0000);
            do_load(55, 16'h5678, 4'b0000);
         end
      join
      push_word(16'h5678, 4'b0000);
      drain_frame(65);
   endtask

   task automatic test_boundary_load;
      push_word(16'h5678, 4'b0000);
      fork
         drain_frame(81);
         begin
            do_load(95, 16'h0009, 4'b0000);
            n_cmp++;
            if (pending !== 1'b0) begin n_mis++; $display("FAIL bypass_pending got=%b want=0", pending); end
         end
      join
   endtask

   task automatic test_dp;
      push_word(16'h0009, 4'b0000);
      fork
         drain_frame(97);
         begin
            n_cmp++;
            if (pending !== 1'b0) begin n_mis++; $display("FAIL bypass_pending2 got=%b want=0", pending); end
            do_load(100, 16'h00A7, 4'b0010);
         end
      join
      push_word(16'h00A7, 4'b0010);
      drain_frame(113);
   endtask

   task automatic test_reset_mid;
      do_load(130, 16'h4321, 4'b1111);
      n_cmp++;
      if (pending !== 1'b1) begin n_mis++; $display("FAIL mid_pending got=%b want=1", pending); end
      go_neg(133);
      rst = 1'b1;
      @(negedge clk);
      n_cmp += 4;
      if (segs !== 8'hFF)    begin n_mis++; $display("FAIL rstmid_segs got=%h want=ff", segs); end
      if (an !== 4'hF)       begin n_mis++; $display("FAIL rstmid_an got=%b want=1111", an); end
      if (pending !== 1'b0)  begin n_mis++; $display("FAIL rstmid_pending got=%b want=0", pending); end
      if (frame_tick !== 1'b0) begin n_mis++; $display("FAIL rstmid_ft got=%b want=0", frame_tick); end
      rst = 1'b0;
      push_word(16'hFFFF, 4'b0000);
      push_word(16'hFFFF, 4'b0000);
      drain_frame(1);
      drain_frame(17);
      n_cmp++;
      if (pending !== 1'b0) begin n_mis++; $display("FAIL post_rst_pending got=%b want=0", pending); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_back_to_back;
      test_boundary_load;
      test_dp;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
